// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding select codes, ALU op codes
// and default datapath widths.
package pipe_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_REG_AW     = 5;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_SUB = 3'b110,
      ALU_SLT = 3'b111
   } alu_op_e;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Decode-side inputs, forwarding sources and execute-side outputs
// of the ID/EX operand stage.
interface id_ex_operand_stage_if
   import pipe_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int REG_AW     = DEF_REG_AW
);
   logic                  StallE;
   logic                  FlushE;
   logic [DATA_WIDTH-1:0] RD1D;
   logic [DATA_WIDTH-1:0] RD2D;
   logic [DATA_WIDTH-1:0] SignImmD;
   logic [REG_AW-1:0]     RsD;
   logic [REG_AW-1:0]     RtD;
   logic [REG_AW-1:0]     RdD;
   logic [2:0]            ALUControlD;
   logic                  ALUSrcD;
   logic                  RegDstD;
   logic                  RegWriteD;
   logic                  MemtoRegD;
   logic                  MemWriteD;
   logic [1:0]            ForwardAE;
   logic [1:0]            ForwardBE;
   logic [DATA_WIDTH-1:0] ALUOutM;
   logic [DATA_WIDTH-1:0] ResultW;

   logic [DATA_WIDTH-1:0] SrcAE;
   logic [DATA_WIDTH-1:0] SrcBE;
   logic [2:0]            ALUControlE;
   logic [DATA_WIDTH-1:0] WriteDataE;
   logic [REG_AW-1:0]     WriteRegE;
   logic [REG_AW-1:0]     RsE;
   logic [REG_AW-1:0]     RtE;
   logic                  RegWriteE;
   logic                  MemtoRegE;
   logic                  MemWriteE;
   logic                  ValidE;

   modport master (
      output StallE, FlushE, RD1D, RD2D, SignImmD,
             RsD, RtD, RdD, ALUControlD, ALUSrcD, RegDstD,
             RegWriteD, MemtoRegD, MemWriteD,
             ForwardAE, ForwardBE, ALUOutM, ResultW,
      input  SrcAE, SrcBE, ALUControlE, WriteDataE,
             WriteRegE, RsE, RtE,
             RegWriteE, MemtoRegE, MemWriteE, ValidE
   );

   modport slave (
      input  StallE, FlushE, RD1D, RD2D, SignImmD,
             RsD, RtD, RdD, ALUControlD, ALUSrcD, RegDstD,
             RegWriteD, MemtoRegD, MemWriteD,
             ForwardAE, ForwardBE, ALUOutM, ResultW,
      output SrcAE, SrcBE, ALUControlE, WriteDataE,
             WriteRegE, RsE, RtE,
             RegWriteE, MemtoRegE, MemWriteE, ValidE
   );

endinterface

// File: rtl/fwd_mux3.sv
// 3:1 operand forwarding mux; any unknown select falls back to the
// register-file value.
module fwd_mux3
   import pipe_pkg::*;
#(
   parameter int W = DEF_DATA_WIDTH
) (
   input  logic [1:0]   sel_i,
   input  logic [W-1:0] reg_i,
   input  logic [W-1:0] wb_i,
   input  logic [W-1:0] mem_i,
   output logic [W-1:0] y_o
);

   always_comb begin
      y_o = reg_i;
      unique case (1'b1)
         (sel_i == FWD_WB):  y_o = wb_i;
         (sel_i == FWD_MEM): y_o = mem_i;
         default:            y_o = reg_i;
      endcase
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX register with forwarding and immediate mux feeding the ALU.
// Define EXE_FORWARD_EN to enable the ResultW/ALUOutM forwarding paths.
module id_ex_operand_stage
   import pipe_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int REG_AW     = DEF_REG_AW
) (
   input logic                  clock,
   input logic                  reset_n,
   id_ex_operand_stage_if.slave bus
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] rd1;
      logic [DATA_WIDTH-1:0] rd2;
      logic [DATA_WIDTH-1:0] imm;
      logic [REG_AW-1:0]     rs;
      logic [REG_AW-1:0]     rt;
      logic [REG_AW-1:0]     rd;
      logic [2:0]            alu;
      logic                  alu_src;
      logic                  reg_dst;
      logic                  reg_write;
      logic                  mem_to_reg;
      logic                  mem_write;
      logic                  valid;
   } id_ex_t;

   id_ex_t ex_q, ex_d;

   logic [1:0]            sel_a, sel_b;
   logic [DATA_WIDTH-1:0] wb_v, mem_v;
   logic [DATA_WIDTH-1:0] src_a, wdata;

   always_comb begin
      ex_d = ex_q;
      if (bus.FlushE) begin
         ex_d = '0;
      end else if (!bus.StallE) begin
         ex_d.rd1        = bus.RD1D;
         ex_d.rd2        = bus.RD2D;
         ex_d.imm        = bus.SignImmD;
         ex_d.rs         = bus.RsD;
         ex_d.rt         = bus.RtD;
         ex_d.rd         = bus.RdD;
         ex_d.alu        = bus.ALUControlD;
         ex_d.alu_src    = bus.ALUSrcD;
         ex_d.reg_dst    = bus.RegDstD;
         ex_d.reg_write  = bus.RegWriteD;
         ex_d.mem_to_reg = bus.MemtoRegD;
         ex_d.mem_write  = bus.MemWriteD;
         ex_d.valid      = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) ex_q <= '0;
      else          ex_q <= ex_d;
   end

`ifdef EXE_FORWARD_EN
   assign sel_a = bus.ForwardAE;
   assign sel_b = bus.ForwardBE;
   assign wb_v  = bus.ResultW;
   assign mem_v = bus.ALUOutM;
`else
   // Hazard unit stalls instead; forwarding inputs are deliberately dead.
   assign sel_a = FWD_REG;
   assign sel_b = FWD_REG;
   assign wb_v  = '0;
   assign mem_v = '0;
   wire unused_fwd = ^{bus.ForwardAE, bus.ForwardBE,
                       bus.ResultW, bus.ALUOutM};
`endif

   fwd_mux3 #(.W(DATA_WIDTH)) u_fwd_a (
      .sel_i (sel_a),
      .reg_i (ex_q.rd1),
      .wb_i  (wb_v),
      .mem_i (mem_v),
      .y_o   (src_a)
   );

   fwd_mux3 #(.W(DATA_WIDTH)) u_fwd_b (
      .sel_i (sel_b),
      .reg_i (ex_q.rd2),
      .wb_i  (wb_v),
      .mem_i (mem_v),
      .y_o   (wdata)
   );

   assign bus.SrcAE       = src_a;
   assign bus.WriteDataE  = wdata;
   assign bus.SrcBE       = ex_q.alu_src ? ex_q.imm : wdata;
   assign bus.ALUControlE = ex_q.alu;
   assign bus.WriteRegE   = ex_q.reg_dst ? ex_q.rd : ex_q.rt;
   assign bus.RsE         = ex_q.rs;
   assign bus.RtE         = ex_q.rt;
   assign bus.RegWriteE   = ex_q.reg_write;
   assign bus.MemtoRegE   = ex_q.mem_to_reg;
   assign bus.MemWriteE   = ex_q.mem_write;
   assign bus.ValidE      = ex_q.valid;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed cases plus random traffic
// against an abstract model of the E register and operand selection.
module tb_id_ex_operand_stage;

`ifdef EXE_FORWARD_EN
   localparam bit FWD_ON = 1'b1;
`else
   localparam bit FWD_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   fails = 0;
   bit   chk_en = 1'b0;

   always #5 clk = ~clk;

   id_ex_operand_stage_if #(.DATA_WIDTH(32), .REG_AW(5)) bus ();

   id_ex_operand_stage #(.DATA_WIDTH(32), .REG_AW(5)) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   // model of what the E stage currently holds
   logic [31:0] m_rd1 = '0, m_rd2 = '0, m_imm = '0;
   logic [4:0]  m_rs = '0, m_rt = '0, m_rd = '0;
   logic [2:0]  m_alu = '0;
   logic        m_asrc = 0, m_rdst = 0, m_rw = 0;
   logic        m_m2r = 0, m_mw = 0, m_v = 0;

   always @(posedge clk) begin
      if (!rst_n || bus.FlushE) begin
         m_rd1 = '0; m_rd2 = '0; m_imm = '0;
         m_rs = '0; m_rt = '0; m_rd = '0; m_alu = '0;
         m_asrc = 0; m_rdst = 0; m_rw = 0;
         m_m2r = 0; m_mw = 0; m_v = 0;
      end else if (!bus.StallE) begin
         m_rd1 = bus.RD1D; m_rd2 = bus.RD2D; m_imm = bus.SignImmD;
         m_rs = bus.RsD; m_rt = bus.RtD; m_rd = bus.RdD;
         m_alu = bus.ALUControlD;
         m_asrc = bus.ALUSrcD; m_rdst = bus.RegDstD;
         m_rw = bus.RegWriteD; m_m2r = bus.MemtoRegD;
         m_mw = bus.MemWriteD; m_v = 1'b1;
      end
   end

   function automatic logic [31:0] fwd(logic [1:0] s, logic [31:0] r);
      if (FWD_ON && s == 2'd1) return bus.ResultW;
      if (FWD_ON && s == 2'd2) return bus.ALUOutM;
      return r;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         logic [31:0] wd;
         wd = fwd(bus.ForwardBE, m_rd2);
         chk("m_srca", bus.SrcAE, fwd(bus.ForwardAE, m_rd1));
         chk("m_wdata", bus.WriteDataE, wd);
         chk("m_srcb", bus.SrcBE, m_asrc ? m_imm : wd);
         chk("m_alu", 32'(bus.ALUControlE), 32'(m_alu));
         chk("m_wreg", 32'(bus.WriteRegE), 32'(m_rdst ? m_rd : m_rt));
         chk("m_rs", 32'(bus.RsE), 32'(m_rs));
         chk("m_rt", 32'(bus.RtE), 32'(m_rt));
         chk("m_ctl", {28'd0, bus.RegWriteE, bus.MemtoRegE,
                       bus.MemWriteE, bus.ValidE},
             {28'd0, m_rw, m_m2r, m_mw, m_v});
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_d();
      bus.StallE = 0; bus.FlushE = 0;
      bus.RD1D = '0; bus.RD2D = '0; bus.SignImmD = '0;
      bus.RsD = '0; bus.RtD = '0; bus.RdD = '0;
      bus.ALUControlD = '0; bus.ALUSrcD = 0; bus.RegDstD = 0;
      bus.RegWriteD = 0; bus.MemtoRegD = 0; bus.MemWriteD = 0;
      bus.ForwardAE = '0; bus.ForwardBE = '0;
      bus.ALUOutM = '0; bus.ResultW = '0;
   endtask

   task automatic rand_d();
      bus.RD1D = $urandom; bus.RD2D = $urandom; bus.SignImmD = $urandom;
      bus.RsD = 5'($urandom); bus.RtD = 5'($urandom); bus.RdD = 5'($urandom);
      bus.ALUControlD = 3'($urandom);
      bus.ALUSrcD = 1'($urandom); bus.RegDstD = 1'($urandom);
      bus.RegWriteD = 1'($urandom); bus.MemtoRegD = 1'($urandom);
      bus.MemWriteD = 1'($urandom);
   endtask

   initial begin
      clear_d();
      rst_n = 0;
      cyc();
      cyc();
      chk_en = 1;
      chk("rst_valid", 32'(bus.ValidE), 32'd0);
      chk("rst_regwrite", 32'(bus.RegWriteE), 32'd0);
      chk("rst_memwrite", 32'(bus.MemWriteE), 32'd0);
      chk("rst_srca", bus.SrcAE, 32'd0);
      chk("rst_srcb", bus.SrcBE, 32'd0);

      rst_n = 1;
      bus.RD1D = 32'd6; bus.RD2D = 32'd3; bus.ALUControlD = 3'd2;
      cyc();
      chk("ld_srca", bus.SrcAE, 32'd6);
      chk("ld_srcb", bus.SrcBE, 32'd3);
      chk("ld_alu", 32'(bus.ALUControlE), 32'd2);
      chk("ld_valid", 32'(bus.ValidE), 32'd1);

      bus.StallE = 1;
      bus.ForwardAE = 2'b10; bus.ALUOutM = 32'h55;
      #1;
      chk("fwd_mem", bus.SrcAE, FWD_ON ? 32'h55 : 32'h6);
      bus.ForwardAE = 2'b01; bus.ResultW = 32'h77;
      #1;
      chk("fwd_wb", bus.SrcAE, FWD_ON ? 32'h77 : 32'h6);
      bus.ForwardAE = 2'b11;
      #1;
      chk("fwd_11", bus.SrcAE, 32'h6);

      bus.StallE = 0; bus.ForwardAE = '0;
      bus.ALUSrcD = 1; bus.SignImmD = 32'hFFFF_FFFC;
      bus.RegDstD = 1; bus.RdD = 5'd9; bus.RtD = 5'd4;
      cyc();
      chk("imm_srcb", bus.SrcBE, 32'hFFFF_FFFC);
      chk("imm_wreg", 32'(bus.WriteRegE), 32'd9);
      chk("imm_wdata", bus.WriteDataE, 32'd3);

      bus.StallE = 1;
      for (int i = 0; i < 3; i++) begin
         rand_d();
         cyc();
         chk("stall_srcb", bus.SrcBE, 32'hFFFF_FFFC);
         chk("stall_wreg", 32'(bus.WriteRegE), 32'd9);
      end
      bus.StallE = 0;
      bus.RD1D = 32'h1234; bus.ALUSrcD = 0; bus.RD2D = 32'h42;
      bus.RegDstD = 0; bus.RtD = 5'd17;
      cyc();
      chk("rel_srca", bus.SrcAE, 32'h1234);
      chk("rel_srcb", bus.SrcBE, 32'h42);
      chk("rel_wreg", 32'(bus.WriteRegE), 32'd17);

      bus.FlushE = 1; bus.StallE = 1; bus.RegWriteD = 1;
      cyc();
      chk("flush_rw", 32'(bus.RegWriteE), 32'd0);
      chk("flush_valid", 32'(bus.ValidE), 32'd0);
      chk("flush_srca", bus.SrcAE, 32'd0);

      bus.FlushE = 0; bus.StallE = 0;
      cyc();
      chk("pre_rst_valid", 32'(bus.ValidE), 32'd1);
      bus.StallE = 1; rst_n = 0;
      cyc();
      chk("rst_stall_valid", 32'(bus.ValidE), 32'd0);
      chk("rst_stall_rw", 32'(bus.RegWriteE), 32'd0);
      rst_n = 1; bus.StallE = 0;

      for (int i = 0; i < 400; i++) begin
         rand_d();
         rst_n = ($urandom_range(0, 49) != 0);
         bus.FlushE = ($urandom_range(0, 9) == 0);
         bus.StallE = ($urandom_range(0, 3) == 0);
         bus.ForwardAE = 2'($urandom);
         bus.ForwardBE = 2'($urandom);
         bus.ALUOutM = $urandom;
         bus.ResultW = $urandom;
         cyc();
      end

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
